// File: rtl/mar_burst.sv
// Memory address register: bus load, single step, autonomous post-increment burst, base/limit wrap window.
// Latency: load/step/ack take effect at the capturing edge; done/wrapped are registered pulses one cycle later.
// Backpressure: a burst request holds its address and mem_req until mem_ack is seen; no timeout.
module mar_burst #(
    parameter int WIDTH = 16,
    parameter int LEN_W = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_bus,
    input  logic             i_load,
    input  logic             i_load_base,
    input  logic             i_load_limit,
    input  logic             i_step,
    input  logic             i_wrap_en,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_burst_len,
    input  logic             i_mem_ack,
    output logic [WIDTH-1:0] o_address,
    output logic             o_mem_req,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_wrapped
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_address;
    logic [WIDTH-1:0] r_base;
    logic [WIDTH-1:0] r_limit;
    logic [LEN_W-1:0] r_count;
    logic             r_done;
    logic             r_wrapped;

    logic [WIDTH-1:0] w_adv_addr;
    logic             w_adv_wraps;
    logic             w_idle;
    logic             w_in_burst;
    logic             w_start_burst;
    logic             w_start_zero;
    logic             w_step_adv;
    logic             w_burst_ack;
    logic             w_last_ack;
    logic             w_advance;

    // Advance rule: wrap to base only when sitting exactly on limit with wrap enabled,
    // otherwise a plain modulo-2^WIDTH increment (limit is irrelevant then).
    always_comb begin
        w_adv_wraps = i_wrap_en && (r_address == r_limit);
        w_adv_addr  = w_adv_wraps ? r_base : (r_address + WIDTH'(1));
    end

    // Command decode; every IDLE-only command is masked while a burst owns the register.
    always_comb begin
        w_idle        = (r_state == S_IDLE);
        w_in_burst    = (r_state == S_BURST);
        w_start_burst = w_idle && i_start && (i_burst_len != '0);
        w_start_zero  = w_idle && i_start && (i_burst_len == '0);
        // start wins over step, load wins over step
        w_step_adv    = w_idle && i_step && !i_load && !i_start;
        w_burst_ack   = w_in_burst && i_mem_ack;
        w_last_ack    = w_burst_ack && (r_count == LEN_W'(1));
        w_advance     = w_step_adv || w_burst_ack;
    end

    // State register
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: enter BURST on a non-empty start, leave on the final ack
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_burst) begin
                    w_state_nxt = S_BURST;
                end
            end
            S_BURST: begin
                if (w_last_ack) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode: request and busy follow the state register directly so reset clears them at once
    always_comb begin
        o_mem_req = 1'b0;
        o_busy    = 1'b0;
        case (r_state)
            S_BURST: begin
                o_mem_req = 1'b1;
                o_busy    = 1'b1;
            end
            default: begin
                o_mem_req = 1'b0;
                o_busy    = 1'b0;
            end
        endcase
        o_address = r_address;
        o_done    = r_done;
        o_wrapped = r_wrapped;
    end

    // Address register: bus load in IDLE, otherwise advance on step or accepted transfer
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_address <= '0;
        end else if (w_idle && i_load) begin
            r_address <= i_bus;
        end else if (w_advance) begin
            r_address <= w_adv_addr;
        end
    end

    // Window registers; base>limit is allowed, wrap simply fires only at address==limit
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_base  <= '0;
            r_limit <= '1;
        end else begin
            if (w_idle && i_load_base) begin
                r_base <= i_bus;
            end
            if (w_idle && i_load_limit) begin
                r_limit <= i_bus;
            end
        end
    end

    // Remaining-transfer counter, reaches zero on the last ack
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_count <= '0;
        end else if (w_start_burst) begin
            r_count <= i_burst_len;
        end else if (w_burst_ack) begin
            r_count <= r_count - LEN_W'(1);
        end
    end

    // Completion and wrap pulses, each high for exactly the cycle after its causing edge
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_done    <= 1'b0;
            r_wrapped <= 1'b0;
        end else begin
            r_done    <= w_start_zero || w_last_ack;
            r_wrapped <= w_advance && w_adv_wraps;
        end
    end

endmodule

// File: tb/tb_mar_burst.sv
module tb_mar_burst;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [15:0] i_bus;
    logic        i_load, i_load_base, i_load_limit, i_step, i_wrap_en, i_start, i_mem_ack;
    logic [7:0]  i_burst_len;
    logic [15:0] o_address;
    logic        o_mem_req, o_busy, o_done, o_wrapped;

    int total = 0;
    int bad   = 0;

    mar_burst #(.WIDTH(16), .LEN_W(8)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_bus       (i_bus),
        .i_load      (i_load),
        .i_load_base (i_load_base),
        .i_load_limit(i_load_limit),
        .i_step      (i_step),
        .i_wrap_en   (i_wrap_en),
        .i_start     (i_start),
        .i_burst_len (i_burst_len),
        .i_mem_ack   (i_mem_ack),
        .o_address   (o_address),
        .o_mem_req   (o_mem_req),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_wrapped   (o_wrapped)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        ld, lb, ll, st, we, sta;
        logic [7:0]  len;
        logic        ack;
        logic [15:0] bus;
        logic [15:0] ea;
        logic        ereq, ebusy, edone, ewrap;
    } vec_t;

    vec_t vt[$];

    // ---------------- behavioural reference ----------------
    logic [15:0] m_addr, m_base, m_limit;
    int          m_left;
    bit          m_busy, m_done, m_wrap;

    task automatic model_reset();
        m_addr = 16'h0000; m_base = 16'h0000; m_limit = 16'hFFFF;
        m_left = 0; m_busy = 0; m_done = 0; m_wrap = 0;
    endtask

    // {wrapped, next address} from the advance rule
    function automatic logic [16:0] next_of(input logic [15:0] a);
        if (i_wrap_en && a == m_limit) return {1'b1, m_base};
        return {1'b0, 16'(a + 16'd1)};
    endfunction

    task automatic model_edge();
        bit          nd, nw;
        logic [15:0] a;
        logic [16:0] n;
        nd = 0; nw = 0; a = m_addr;
        if (!m_busy) begin
            if (i_load) a = i_bus;
            else if (i_step && !i_start) begin
                n = next_of(m_addr); a = n[15:0]; nw = n[16];
            end
            if (i_load_base)  m_base  = i_bus;
            if (i_load_limit) m_limit = i_bus;
            if (i_start) begin
                if (i_burst_len == 8'd0) nd = 1;
                else begin m_busy = 1; m_left = int'(i_burst_len); end
            end
        end else if (i_mem_ack) begin
            n = next_of(m_addr); a = n[15:0]; nw = n[16];
            m_left = m_left - 1;
            if (m_left == 0) begin m_busy = 0; nd = 1; end
        end
        m_addr = a; m_done = nd; m_wrap = nw;
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic ld, lb, ll, st, we, sta, input logic [7:0] len,
                         input logic ack, input logic [15:0] bus);
        i_load = ld; i_load_base = lb; i_load_limit = ll; i_step = st;
        i_wrap_en = we; i_start = sta; i_burst_len = len; i_mem_ack = ack; i_bus = bus;
    endtask

    task automatic idle_in();
        drive(0, 0, 0, 0, 0, 0, 8'd0, 0, 16'h0000);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_out(input string nm, input logic [15:0] a, input logic rq, bz, dn, wr);
        chk({nm, " addr"},    32'(o_address), 32'(a));
        chk({nm, " mem_req"}, 32'(o_mem_req), 32'(rq));
        chk({nm, " busy"},    32'(o_busy),    32'(bz));
        chk({nm, " done"},    32'(o_done),    32'(dn));
        chk({nm, " wrapped"}, 32'(o_wrapped), 32'(wr));
    endtask

    function automatic vec_t v(input logic ld, lb, ll, st, we, sta, input logic [7:0] len,
                               input logic ack, input logic [15:0] bus, input logic [15:0] ea,
                               input logic rq, dn, wr);
        vec_t r;
        r.ld = ld; r.lb = lb; r.ll = ll; r.st = st; r.we = we; r.sta = sta;
        r.len = len; r.ack = ack; r.bus = bus;
        r.ea = ea; r.ereq = rq; r.ebusy = rq; r.edone = dn; r.ewrap = wr;
        return r;
    endfunction

    initial begin
        // directed table:  ld lb ll st we sta len ack bus  | addr req done wrap
        vt.push_back(v(1,0,0,0,0,0,8'd0,0,16'h1234, 16'h1234,0,0,0)); // load
        vt.push_back(v(0,0,0,1,0,0,8'd0,0,16'h0000, 16'h1235,0,0,0)); // step
        vt.push_back(v(1,0,0,1,0,0,8'd0,0,16'h0050, 16'h0050,0,0,0)); // load beats step
        vt.push_back(v(1,0,0,0,0,0,8'd0,0,16'h0100, 16'h0100,0,0,0));
        vt.push_back(v(0,0,0,0,0,1,8'd3,0,16'h0000, 16'h0100,1,0,0)); // start 3
        vt.push_back(v(0,0,0,0,0,0,8'd0,1,16'h0000, 16'h0101,1,0,0));
        vt.push_back(v(0,0,0,0,0,0,8'd0,1,16'h0000, 16'h0102,1,0,0));
        vt.push_back(v(0,0,0,0,0,0,8'd0,1,16'h0000, 16'h0103,0,1,0)); // last ack
        vt.push_back(v(0,0,0,0,0,0,8'd0,1,16'h0000, 16'h0103,0,0,0)); // ack in idle ignored
        vt.push_back(v(0,1,0,0,0,0,8'd0,0,16'h0010, 16'h0103,0,0,0)); // base
        vt.push_back(v(0,0,1,0,0,0,8'd0,0,16'h0013, 16'h0103,0,0,0)); // limit
        vt.push_back(v(1,0,0,0,1,0,8'd0,0,16'h0012, 16'h0012,0,0,0));
        vt.push_back(v(0,0,0,0,1,1,8'd4,0,16'h0000, 16'h0012,1,0,0)); // start 4 wrapped
        vt.push_back(v(0,0,0,0,1,0,8'd0,1,16'h0000, 16'h0013,1,0,0));
        vt.push_back(v(0,0,0,0,1,0,8'd0,1,16'h0000, 16'h0010,1,0,1)); // wrap
        vt.push_back(v(0,0,0,0,1,0,8'd0,1,16'h0000, 16'h0011,1,0,0));
        vt.push_back(v(0,0,0,0,1,0,8'd0,1,16'h0000, 16'h0012,0,1,0));
        vt.push_back(v(0,0,0,0,1,0,8'd0,0,16'h0000, 16'h0012,0,0,0));
        vt.push_back(v(1,0,0,0,0,0,8'd0,0,16'h0200, 16'h0200,0,0,0));
        vt.push_back(v(0,0,0,0,0,1,8'd2,0,16'h0000, 16'h0200,1,0,0)); // start 2
        vt.push_back(v(1,1,1,1,0,1,8'd7,0,16'h0555, 16'h0200,1,0,0)); // stall, cmds ignored
        vt.push_back(v(0,0,0,1,0,0,8'd0,0,16'h0000, 16'h0200,1,0,0));
        vt.push_back(v(0,0,0,0,0,0,8'd0,0,16'h0000, 16'h0200,1,0,0));
        vt.push_back(v(0,0,0,0,0,0,8'd0,1,16'h0000, 16'h0201,1,0,0));
        vt.push_back(v(0,0,0,0,0,0,8'd0,1,16'h0000, 16'h0202,0,1,0));
        vt.push_back(v(0,0,0,0,0,0,8'd0,0,16'h0000, 16'h0202,0,0,0));
        vt.push_back(v(0,0,0,1,0,1,8'd0,0,16'h0000, 16'h0202,0,1,0)); // zero length, step ignored
        vt.push_back(v(0,0,0,0,0,0,8'd0,0,16'h0000, 16'h0202,0,0,0));

        // reset state
        idle_in();
        i_reset = 1'b0;
        #12;
        chk_out("reset", 16'h0000, 0, 0, 0, 0);
        @(negedge i_clk);
        i_reset = 1'b1;

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].ld, vt[i].lb, vt[i].ll, vt[i].st, vt[i].we, vt[i].sta,
                  vt[i].len, vt[i].ack, vt[i].bus);
            tick();
            chk({"row", $sformatf("%0d", i), " addr"},    32'(o_address), 32'(vt[i].ea));
            chk({"row", $sformatf("%0d", i), " mem_req"}, 32'(o_mem_req), 32'(vt[i].ereq));
            chk({"row", $sformatf("%0d", i), " busy"},    32'(o_busy),    32'(vt[i].ebusy));
            chk({"row", $sformatf("%0d", i), " done"},    32'(o_done),    32'(vt[i].edone));
            chk({"row", $sformatf("%0d", i), " wrapped"}, 32'(o_wrapped), 32'(vt[i].ewrap));
        end

        // reset in the middle of a 5-transfer burst, after two acks
        drive(1, 0, 0, 0, 0, 0, 8'd0, 0, 16'h0300); tick();
        drive(0, 0, 0, 0, 0, 1, 8'd5, 0, 16'h0000); tick();
        drive(0, 0, 0, 0, 0, 0, 8'd0, 1, 16'h0000); tick();
        tick();
        chk_out("midburst", 16'h0302, 1, 1, 0, 0);
        #2;
        i_reset = 1'b0;
        #1;
        chk_out("async reset", 16'h0000, 0, 0, 0, 0);
        @(negedge i_clk);
        i_reset = 1'b1;
        idle_in();
        tick();
        chk_out("post reset", 16'h0000, 0, 0, 0, 0);

        // limit defaults to all-ones after reset
        drive(1, 0, 0, 0, 0, 0, 8'd0, 0, 16'hFFFF); tick();
        drive(0, 0, 0, 1, 0, 0, 8'd0, 0, 16'h0000); tick();
        chk_out("ffff step nowrap", 16'h0000, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 8'd0, 0, 16'hFFFF); tick();
        drive(0, 0, 0, 1, 1, 0, 8'd0, 0, 16'h0000); tick();
        chk_out("ffff step wrap", 16'h0000, 0, 0, 0, 1);
        idle_in(); tick();
        chk_out("wrap pulse ends", 16'h0000, 0, 0, 0, 0);

        // randomized run against the reference model
        i_reset = 1'b0;
        #2;
        model_reset();
        @(negedge i_clk);
        i_reset = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            i_load       = ($urandom_range(0, 7) == 0);
            i_load_base  = ($urandom_range(0, 9) == 0);
            i_load_limit = ($urandom_range(0, 9) == 0);
            i_step       = ($urandom_range(0, 2) == 0);
            i_wrap_en    = ($urandom_range(0, 9) < 7);
            i_start      = ($urandom_range(0, 5) == 0);
            i_burst_len  = 8'($urandom_range(0, 6));
            i_mem_ack    = ($urandom_range(0, 1) == 1);
            i_bus        = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 24));
            model_edge();
            tick();
            chk_out($sformatf("rand%0d", c), m_addr, m_busy, m_busy, m_done, m_wrap);
            if ($urandom_range(0, 299) == 0) begin
                #2;
                i_reset = 1'b0;
                #1;
                model_reset();
                chk_out($sformatf("rand%0d reset", c), m_addr, 0, 0, 0, 0);
                @(negedge i_clk);
                i_reset = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
